plic_gateway_priority_core: RTL
===============================

// Module: plic_gateway_priority_core
// PURPOSE
// - Next-gen PLIC pending/priority core: per-source gateway FSM, programmable priority, priority threshold,
//   registered max-priority arbiter, claim/complete registers. Sits between per-source enable masking and the hart irq.
// - Source s (0..N_INTERRUPTS-1) is interrupt ID s+1; ID 0 = "no interrupt".
// PARAMETERS
// - N_INTERRUPTS  32  number of sources, 1..1023
// - PRIO_BITS     3   priority width, 1..8; priority 0 = never interrupts
// - ID_BITS       10  claim ID width; must satisfy 2**ID_BITS > N_INTERRUPTS
// PORTS
// - clk             in   1             clock
// - n_rst           in   1             async active-low reset
// - irq_src         in   N_INTERRUPTS  raw source requests, synchronous to clk
// - irq_enable      in   N_INTERRUPTS  per-source enables from enable block
// - base_addr       in   32            register window base
// - addr            in   32            bus address (byte)
// - wen             in   1             write strobe, 1 cycle per access
// - ren             in   1             read strobe, 1 cycle per access
// - wdata           in   32            write data
// - rdata           out  32            read data, combinational from addr
// - addr_valid      out  1             addr hits a register below
// - irq_out         out  1             registered hart interrupt request
// BEHAVIOUR
// - Map, off = addr-base_addr: 0x0000+4*k priority ID k (k=0 RO zero, k>N invalid); 0x1000+4*w pending word w
//   (bit j = ID 32w+j, RO, writes ignored); 0x2000 threshold (PRIO_BITS, RW); 0x2004 claim(R)/complete(W);
//   0x3000+4*w trigger-type word w (see CONFIGURATION). Other offsets: addr_valid=0, rdata=0, writes ignored.
// - Reset: all priorities, threshold, pending, trigger-type = 0; all gateways IDLE; best_id=0; irq_out=0.
// - Writes: only wdata[PRIO_BITS-1:0] kept; upper bits read back 0.
// - Gateway per source: IDLE -> PENDING when level request (irq_src&irq_enable) seen at clk edge;
//   PENDING -> CLAIMED on claim read returning its ID; CLAIMED -> IDLE on complete write of its ID.
//   Requests in PENDING/CLAIMED are ignored (level: source must still be high after complete to re-pend).
//   Pending bit = gateway in PENDING. irq_enable deassert does not clear pending.
// - Arbiter: eligible = PENDING && enabled && priority>threshold. Highest priority wins; tie -> lowest ID.
//   Result registered: best_id/irq_out reflect state from previous cycle (latency 1 from pend to irq_out).
//   irq_out = (best_id!=0).
// - Claim: ren at 0x2004 returns {zeros, best_id} same cycle; that source -> CLAIMED at next edge and is
//   excluded from arbitration in the cycle its claim is committed. best_id=0 -> returns 0, no side effect.
// - Complete: wen at 0x2004 with wdata[ID_BITS-1:0]=ID of a CLAIMED source -> IDLE; any other ID (0, >N,
//   not CLAIMED) ignored. Source re-pends at earliest on the edge after complete.
// - Simultaneous claim read and request of same source: claim wins, request ignored.
// - Priority/threshold writes take effect on arbitration result one cycle after the write edge.
// - Reset mid-operation: all state cleared asynchronously; claimed-but-uncompleted IDs are lost.
// CONFIGURATION
// - PLIC_EDGE_TRIGGER_EN defined: trigger-type regs RW, bit=1 selects edge mode for that source.
//   Edge mode: rising edge of irq_src (registered prev sample) is the request; an edge arriving while
//   PENDING is absorbed; while CLAIMED it sets a 1-deep re-pend flag -> source goes PENDING on complete
//   edge instead of IDLE. Level mode unchanged.
// - Not defined: trigger-type offsets still addr_valid, read 0, writes ignored; all sources level mode,
//   no edge-detect or re-pend flops synthesised.
// TESTING
// - Reset -> rdata at 0x1000 = 0, irq_out=0; write prio ID3=5 and read back 5; write 0xFF -> reads 0x7.
// - prio ID3=5,ID7=5, threshold=0, pulse-hold src 2,6 high -> irq_out=1 next cycle, claim read returns 3.
// - threshold=5 with only ID3 (prio 5) pending -> irq_out=0; threshold=4 -> irq_out=1 one cycle later.
// - Claim ID3 with src 2 held high -> pending bit clear, not re-pended; complete ID9 ignored; complete ID3
//   -> pending bit 3 set again next cycle.
// - Claim read with no eligible source -> returns 0, no state change; addr off 0x4000 -> addr_valid=0.
// - PLIC_EDGE_TRIGGER_EN, type ID4=1: two rising edges while claimed -> after complete ID4 pending once,
//   second claim returns 4, third claim returns 0.

Source files
------------

// File: rtl/plic_gateway_priority_core_if.sv
// Register-bus bundle for the PLIC pending/priority core.
// master: drives base_addr/addr/wen/ren/wdata, samples rdata/addr_valid.
// slave : the core; rdata/addr_valid are combinational from addr.
interface plic_gateway_priority_core_if;
  logic [31:0] base_addr;
  logic [31:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_valid;

  modport master (
    output base_addr, addr, wen, ren, wdata,
    input  rdata, addr_valid
  );

  modport slave (
    input  base_addr, addr, wen, ren, wdata,
    output rdata, addr_valid
  );
endinterface

// File: rtl/plic_gateway_priority_core.sv
// PLIC pending/priority core: per-source gateway FSM, programmable priorities,
// threshold, registered max-priority arbiter and claim/complete register.
// Source s is interrupt ID s+1; ID 0 means "no interrupt".
// Ports:
//   clk          clock
//   n_rst        async active-low reset
//   irq_src_i    raw source requests (synchronous to clk)
//   irq_enable_i per-source enables
//   bus          register bus (slave modport); rdata/addr_valid combinational
//   irq_out_o    registered hart interrupt request
// Register window (offset = addr - base_addr):
//   0x0000+4k priority ID k, 0x1000+4w pending word w, 0x2000 threshold,
//   0x2004 claim/complete, 0x3000+4w trigger-type word w.
// Optional feature: define PLIC_EDGE_TRIGGER_EN for per-source edge-triggered
// gateways with a 1-deep re-pend flag; otherwise all sources are level mode.
module plic_gateway_priority_core #(
  parameter int unsigned N_INTERRUPTS = 32,
  parameter int unsigned PRIO_BITS    = 3,
  parameter int unsigned ID_BITS      = 10
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [N_INTERRUPTS-1:0]       irq_src_i,
  input  logic [N_INTERRUPTS-1:0]       irq_enable_i,
  plic_gateway_priority_core_if.slave   bus,
  output logic                          irq_out_o
);

  // Word count for pending/trigger maps: bit j of word w is ID 32w+j.
  localparam int unsigned N_WORDS = N_INTERRUPTS / 32 + 1;
  localparam int unsigned VEC_W   = N_WORDS * 32;

  localparam logic [1:0] GW_IDLE    = 2'b00;
  localparam logic [1:0] GW_PENDING = 2'b01;
  localparam logic [1:0] GW_CLAIMED = 2'b10;

  logic [1:0]           gw_q   [N_INTERRUPTS];
  logic [1:0]           gw_d   [N_INTERRUPTS];
  logic [PRIO_BITS-1:0] prio_q [N_INTERRUPTS];
  logic [PRIO_BITS-1:0] prio_d [N_INTERRUPTS];
  logic [PRIO_BITS-1:0] thresh_q, thresh_d;
  logic [ID_BITS-1:0]   best_id_q, best_id_d;
  logic                 irq_q, irq_d;
  logic [PRIO_BITS-1:0] best_prio_c;

  logic [31:0]             off_c;
  logic [9:0]              word_c;
  logic                    base_ok_c;
  logic                    sel_prio_c, sel_pend_c, sel_thr_c, sel_claim_c, sel_trig_c;
  logic                    claim_c, cmpl_c;
  logic [ID_BITS-1:0]      cmpl_id_c;
  logic [N_INTERRUPTS-1:0] req_c;
  logic [VEC_W-1:0]        pend_vec_c;
  logic [31:0]             rdata_c;
  logic                    unused_bits_c;

`ifdef PLIC_EDGE_TRIGGER_EN
  logic [N_INTERRUPTS-1:0] trig_q, trig_d;
  logic [N_INTERRUPTS-1:0] prev_q;
  logic [N_INTERRUPTS-1:0] repend_q, repend_d;
  logic [N_INTERRUPTS-1:0] rep_c;
  logic [VEC_W-1:0]        trig_vec_c;
`endif

  // Address decode: word-aligned offsets inside the 16 KiB window only.
  assign off_c       = bus.addr - bus.base_addr;
  assign word_c      = off_c[11:2];
  assign base_ok_c   = (off_c[31:14] == 18'd0) && (off_c[1:0] == 2'b00);
  assign sel_prio_c  = base_ok_c && (off_c[13:12] == 2'd0) && (32'(word_c) <= N_INTERRUPTS);
  assign sel_pend_c  = base_ok_c && (off_c[13:12] == 2'd1) && (32'(word_c) < N_WORDS);
  assign sel_thr_c   = base_ok_c && (off_c[13:0] == 14'h2000);
  assign sel_claim_c = base_ok_c && (off_c[13:0] == 14'h2004);
  assign sel_trig_c  = base_ok_c && (off_c[13:12] == 2'd3) && (32'(word_c) < N_WORDS);

  assign bus.addr_valid = sel_prio_c | sel_pend_c | sel_thr_c | sel_claim_c | sel_trig_c;

  // A claim only has a side effect when there is a winner to hand out.
  assign claim_c   = bus.ren && sel_claim_c && (best_id_q != '0);
  assign cmpl_c    = bus.wen && sel_claim_c;
  assign cmpl_id_c = bus.wdata[ID_BITS-1:0];

  assign unused_bits_c = ^{bus.wdata, bus.ren};

`ifdef PLIC_EDGE_TRIGGER_EN
  // Edge sources request on a rising edge; level sources on the raw level.
  assign req_c = irq_src_i & irq_enable_i & ~(prev_q & trig_q);
  assign rep_c = repend_q | (trig_q & req_c);
`else
  assign req_c = irq_src_i & irq_enable_i;
`endif

  // Pending-bit image indexed by ID (bit 0 = ID 0, always clear).
  always_comb begin
    pend_vec_c = '0;
    for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
      pend_vec_c[s + 1] = (gw_q[s] == GW_PENDING);
    end
  end

`ifdef PLIC_EDGE_TRIGGER_EN
  always_comb begin
    trig_vec_c = '0;
    for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
      trig_vec_c[s + 1] = trig_q[s];
    end
  end
`endif

  // Read mux.
  always_comb begin
    rdata_c = '0;
    if (sel_prio_c) begin
      for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
        if (word_c == 10'(s + 1)) rdata_c = 32'(prio_q[s]);
      end
    end
    if (sel_pend_c) begin
      for (int unsigned w = 0; w < N_WORDS; w++) begin
        if (word_c == 10'(w)) rdata_c = pend_vec_c[w*32 +: 32];
      end
    end
`ifdef PLIC_EDGE_TRIGGER_EN
    if (sel_trig_c) begin
      for (int unsigned w = 0; w < N_WORDS; w++) begin
        if (word_c == 10'(w)) rdata_c = trig_vec_c[w*32 +: 32];
      end
    end
`endif
    if (sel_thr_c)   rdata_c = 32'(thresh_q);
    if (sel_claim_c) rdata_c = 32'(best_id_q);
  end

  assign bus.rdata = rdata_c;

  // Register writes and gateway next-state.
  always_comb begin
    thresh_d = thresh_q;
    prio_d   = prio_q;
    gw_d     = gw_q;
`ifdef PLIC_EDGE_TRIGGER_EN
    trig_d   = trig_q;
    repend_d = repend_q;
`endif
    if (bus.wen && sel_thr_c) thresh_d = bus.wdata[PRIO_BITS-1:0];
    for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
      if (bus.wen && sel_prio_c && (word_c == 10'(s + 1))) prio_d[s] = bus.wdata[PRIO_BITS-1:0];
`ifdef PLIC_EDGE_TRIGGER_EN
      if (bus.wen && sel_trig_c && (word_c == 10'((s + 1) / 32))) trig_d[s] = bus.wdata[(s + 1) % 32];
`endif
      case (gw_q[s])
        GW_IDLE: begin
          if (req_c[s]) gw_d[s] = GW_PENDING;
        end
        GW_PENDING: begin
          // A concurrent request is absorbed; the claim wins.
          if (claim_c && (best_id_q == ID_BITS'(s + 1))) gw_d[s] = GW_CLAIMED;
        end
        GW_CLAIMED: begin
`ifdef PLIC_EDGE_TRIGGER_EN
          repend_d[s] = rep_c[s];
`endif
          if (cmpl_c && (cmpl_id_c == ID_BITS'(s + 1))) begin
`ifdef PLIC_EDGE_TRIGGER_EN
            gw_d[s]     = rep_c[s] ? GW_PENDING : GW_IDLE;
            repend_d[s] = 1'b0;
`else
            gw_d[s]     = GW_IDLE;
`endif
          end
        end
        default: gw_d[s] = GW_IDLE;
      endcase
    end
  end

  // Arbiter: strict '>' keeps the lowest ID on priority ties; the source
  // being claimed this cycle is excluded so it cannot be handed out twice.
  always_comb begin
    best_id_d   = '0;
    best_prio_c = '0;
    for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
      if ((gw_q[s] == GW_PENDING) && irq_enable_i[s] && (prio_q[s] > thresh_q) &&
          !(claim_c && (best_id_q == ID_BITS'(s + 1))) && (prio_q[s] > best_prio_c)) begin
        best_prio_c = prio_q[s];
        best_id_d   = ID_BITS'(s + 1);
      end
    end
    irq_d = (best_id_d != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      thresh_q  <= '0;
      best_id_q <= '0;
      irq_q     <= 1'b0;
      for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
        prio_q[s] <= '0;
        gw_q[s]   <= GW_IDLE;
      end
    end else begin
      thresh_q  <= thresh_d;
      best_id_q <= best_id_d;
      irq_q     <= irq_d;
      for (int unsigned s = 0; s < N_INTERRUPTS; s++) begin
        prio_q[s] <= prio_d[s];
        gw_q[s]   <= gw_d[s];
      end
    end
  end

`ifdef PLIC_EDGE_TRIGGER_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      trig_q   <= '0;
      prev_q   <= '0;
      repend_q <= '0;
    end else begin
      trig_q   <= trig_d;
      prev_q   <= irq_src_i;
      repend_q <= repend_d;
    end
  end
`endif

  assign irq_out_o = irq_q;

endmodule
